// File: rtl/mcycle_core.sv
// Multi-cycle 16-bit-encoded core: FETCH/DECODE/EXEC/MEM/WB over req/ack instruction and data memories.
// Define MCYC_TRACE_EN to add retirement trace outputs (trace_pc/wen/waddr/wdata).
module mcycle_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              instr_done,
`ifdef MCYC_TRACE_EN
  output logic [ADDR_W-1:0] trace_pc,
  output logic              trace_wen,
  output logic [2:0]        trace_waddr,
  output logic [DATA_W-1:0] trace_wdata,
`endif
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StMem, StWb} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, alu_q;
  logic [DATA_W-1:0] rf_q [NREG];
  logic              imem_req_q, dmem_req_q, dmem_we_q, done_q;
  logic [ADDR_W-1:0] dmem_addr_q;
  logic [DATA_W-1:0] dmem_wdata_q;

  logic [1:0]        op;
  logic [2:0]        rs, rt, rd;
  logic [4:0]        funct;
  logic [DATA_W-1:0] imm_ext;
  logic              legal_r;

  assign op      = ir_q[15:14];
  assign rs      = ir_q[13:11];
  assign rt      = ir_q[10:8];
  assign rd      = ir_q[7:5];
  assign funct   = ir_q[4:0];
  assign imm_ext = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign legal_r = (funct < 5'd5);

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign instr_done = done_q;
  assign pc         = pc_q;

  logic [DATA_W-1:0] alu_res;

  always_comb begin
    alu_res = '0;
    unique case (op)
      2'b00: begin
        case (funct)
          5'd0:    alu_res = a_q + b_q;
          5'd1:    alu_res = a_q - b_q;
          5'd2:    alu_res = a_q & b_q;
          5'd3:    alu_res = a_q | b_q;
          5'd4:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
          default: alu_res = '0;
        endcase
      end
      2'b01, 2'b10: alu_res = a_q + imm_ext;
      2'b11:        alu_res = '0;
    endcase
  end

  // Retirement happens in whichever state is last for the opcode.
  logic              retire;
  logic [ADDR_W-1:0] next_pc;
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  always_comb begin
    retire   = 1'b0;
    next_pc  = pc_q + ADDR_W'(1);
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = alu_q;
    if (op == 2'b11 && a_q == b_q) next_pc = pc_q + ADDR_W'(1) + imm_ext[ADDR_W-1:0];
    case (state_q)
      StExec: retire = (op == 2'b11);
      StMem:  retire = (op == 2'b10) && dmem_req_q && dmem_ack;
      StWb: begin
        retire = 1'b1;
        if (op == 2'b01) begin
          rf_waddr = rt;
          rf_we    = (rt != 3'd0);
        end else if (op == 2'b00) begin
          rf_we = legal_r && (rd != 3'd0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_q        <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      done_q       <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      done_q <= retire;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
      case (state_q)
        StIdle: begin
          if (run) begin
            state_q    <= StFetch;
            imem_req_q <= 1'b1;
          end
        end
        StFetch: begin
          if (imem_req_q && imem_ack) begin
            ir_q       <= imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= StDecode;
          end
        end
        StDecode: begin
          a_q     <= rf_q[rs];
          b_q     <= rf_q[rt];
          state_q <= StExec;
        end
        StExec: begin
          alu_q <= alu_res;
          if (op == 2'b00) begin
            state_q <= StWb;
          end else if (op != 2'b11) begin
            state_q     <= StMem;
            dmem_req_q  <= 1'b1;
            dmem_we_q   <= (op == 2'b10);
            dmem_addr_q <= alu_res[ADDR_W-1:0];
            if (op == 2'b10) dmem_wdata_q <= b_q;
          end
        end
        StMem: begin
          if (dmem_req_q && dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (op == 2'b01) begin
              alu_q   <= dmem_rdata;
              state_q <= StWb;
            end
          end
        end
        default: ;
      endcase
      // Placed last so the boundary decision overrides the per-state transition.
      if (retire) begin
        pc_q <= next_pc;
        if (run) begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end else begin
          state_q <= StIdle;
        end
      end
    end
  end

`ifdef MCYC_TRACE_EN
  logic [ADDR_W-1:0] trace_pc_q;
  logic              trace_wen_q;
  logic [2:0]        trace_waddr_q;
  logic [DATA_W-1:0] trace_wdata_q;

  assign trace_pc    = trace_pc_q;
  assign trace_wen   = trace_wen_q;
  assign trace_waddr = trace_waddr_q;
  assign trace_wdata = trace_wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_pc_q    <= '0;
      trace_wen_q   <= 1'b0;
      trace_waddr_q <= '0;
      trace_wdata_q <= '0;
    end else begin
      trace_wen_q <= retire && rf_we;
      if (retire) begin
        trace_pc_q    <= pc_q;
        trace_waddr_q <= rf_waddr;
        trace_wdata_q <= rf_wdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mcycle_core.sv
// Scoreboard bench for mcycle_core: an ISA model fills retire/store queues, a memory responder pops them.
module tb_mcycle_core;

  logic        clk = 1'b0;
  logic        reset, run;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, instr_done;
  logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;

  always #5 clk = ~clk;

  mcycle_core dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .instr_done (instr_done),
    .pc         (pc)
  );

  typedef struct packed {logic [15:0] npc; logic [15:0] lat;} ret_t;
  typedef struct packed {logic [15:0] addr; logic [15:0] data;} st_t;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] m_dm [256];
  logic [15:0] m_rf [8];
  ret_t        rq [$];
  st_t         sq [$];
  int          checks = 0, failures = 0;
  int          iw = 0, dw = 0, cyc = 0, fetch_start = 0, d_xfers = 0, dreq_cycles = 0;
  logic        spur = 1'b0;
  logic [15:0] bpc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int f);
    return {2'b00, rs[2:0], rt[2:0], rd[2:0], f[4:0]};
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[1:0], rs[2:0], rt[2:0], imm[7:0]};
  endfunction

  // ISA model: places the instruction at bpc and queues its expected retirement and store.
  task automatic emit(input logic [15:0] ins);
    logic [2:0]  rs, rt, rd;
    logic [4:0]  f;
    logic [15:0] a, b, imm, ea, npc, res;
    int          lat;
    rs  = ins[13:11];
    rt  = ins[10:8];
    rd  = ins[7:5];
    f   = ins[4:0];
    a   = m_rf[rs];
    b   = m_rf[rt];
    imm = {{8{ins[7]}}, ins[7:0]};
    ea  = a + imm;
    npc = bpc + 16'd1;
    lat = 0;
    case (ins[15:14])
      2'b00: begin
        lat = 4 + iw;
        if (f <= 5'd4) begin
          case (f)
            5'd0:    res = a + b;
            5'd1:    res = a - b;
            5'd2:    res = a & b;
            5'd3:    res = a | b;
            default: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
          endcase
          if (rd != 3'd0) m_rf[rd] = res;
        end
      end
      2'b01: begin
        lat = 5 + iw + dw;
        if (rt != 3'd0) m_rf[rt] = m_dm[ea[7:0]];
      end
      2'b10: begin
        lat = 4 + iw + dw;
        m_dm[ea[7:0]] = b;
        sq.push_back({ea, b});
      end
      default: begin
        lat = 3 + iw;
        if (a == b) npc = bpc + 16'd1 + imm;
      end
    endcase
    imem[bpc[7:0]] = ins;
    rq.push_back({npc, lat[15:0]});
    bpc = npc;
  endtask

  task automatic dpre(input int addr, input logic [15:0] val);
    dmem[addr] = val;
    m_dm[addr] = val;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    spur  = 1'b0;
    iw    = 0;
    dw    = 0;
    rq.delete();
    sq.delete();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'hC0FF;  // beq r0,r0,-1: park on self
      dmem[i] = 16'h0;
      m_dm[i] = 16'h0;
    end
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    bpc = 16'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && (rq.size() != 0 || sq.size() != 0); i++) @(negedge clk);
    check({tag, "_drain"}, rq.size() + sq.size(), 0);
    run = 1'b0;
    repeat (25) @(negedge clk);
    check({tag, "_idle"}, {31'd0, imem_req}, 0);
  endtask

  // Memory responder and retirement monitor, sampled on the falling edge.
  initial begin
    int          icnt, dcnt;
    logic        p_ireq, p_iack, p_dreq, p_dack, p_done, p_dwe;
    logic [15:0] p_iaddr, p_daddr, p_dwd;
    ret_t        r;
    st_t         s;
    icnt = 0; dcnt = 0;
    p_ireq = 0; p_iack = 0; p_dreq = 0; p_dack = 0; p_done = 0; p_dwe = 0;
    p_iaddr = 0; p_daddr = 0; p_dwd = 0;
    imem_ack = 0; dmem_ack = 0; imem_rdata = 0; dmem_rdata = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        icnt = 0; dcnt = 0; imem_ack = 0; dmem_ack = 0;
        p_ireq = 0; p_iack = 0; p_dreq = 0; p_dack = 0; p_done = 0;
        continue;
      end
      if (instr_done) begin
        check("done_pulse", {31'd0, p_done}, 0);
        if (rq.size() != 0) begin
          r = rq.pop_front();
          check("retire_pc", pc, r.npc);
          check("fetch_addr", imem_addr, r.npc);
          check("latency", cyc - fetch_start, r.lat);
        end
      end
      if (imem_req && !p_ireq) fetch_start = cyc;
      if (dmem_req) dreq_cycles++;
      if (p_ireq && !p_iack) begin
        check("ireq_hold", {31'd0, imem_req}, 1);
        check("iaddr_stable", imem_addr, p_iaddr);
      end
      if (p_dreq && !p_dack) begin
        check("dreq_hold", {31'd0, dmem_req}, 1);
        check("daddr_stable", dmem_addr, p_daddr);
        check("dwe_stable", {31'd0, dmem_we}, {31'd0, p_dwe});
        check("dwdata_stable", dmem_wdata, p_dwd);
      end
      if (imem_req) begin
        if (icnt == iw) begin
          imem_ack   = 1'b1;
          imem_rdata = imem[imem_addr[7:0]];
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 16'hDEAD;
        end
        icnt++;
      end else begin
        imem_ack   = spur;
        imem_rdata = 16'hDEAD;
        icnt       = 0;
      end
      if (dmem_req) begin
        if (dcnt == dw) begin
          dmem_ack = 1'b1;
          d_xfers++;
          if (dmem_we) begin
            check("st_pending", {31'd0, sq.size() != 0}, 1);
            if (sq.size() != 0) begin
              s = sq.pop_front();
              check("st_addr", dmem_addr, s.addr);
              check("st_data", dmem_wdata, s.data);
            end
            dmem[dmem_addr[7:0]] = dmem_wdata;
          end else begin
            dmem_rdata = dmem[dmem_addr[7:0]];
          end
        end else begin
          dmem_ack   = 1'b0;
          dmem_rdata = 16'hBEEF;
        end
        dcnt++;
      end else begin
        dmem_ack   = spur;
        dmem_rdata = 16'hBEEF;
        dcnt       = 0;
      end
      p_ireq = imem_req; p_iack = imem_ack; p_iaddr = imem_addr; p_done = instr_done;
      p_dreq = dmem_req; p_dack = dmem_ack; p_daddr = dmem_addr; p_dwe = dmem_we;
      p_dwd  = dmem_wdata;
    end
  end

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    do_reset();

    // Reset state, then acks with no request outstanding.
    check("rst_pc", pc, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_req", {31'd0, imem_req}, 0);
    check("rst_dmem_req", {31'd0, dmem_req}, 0);
    check("rst_dmem_we", {31'd0, dmem_we}, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    check("rst_instr_done", {31'd0, instr_done}, 0);
    spur = 1'b1;
    repeat (5) @(negedge clk);
    check("spur_pc", pc, 0);
    check("spur_imem_req", {31'd0, imem_req}, 0);
    check("spur_dmem_req", {31'd0, dmem_req}, 0);
    check("spur_done", {31'd0, instr_done}, 0);
    spur = 1'b0;

    // Load then store.
    dpre(5, 16'h0007);
    emit(16'h4105);
    emit(16'h8106);
    run = 1'b1;
    drain("ldst");

    // ALU ops incl. wrap-around add, signed slt and both branch outcomes.
    do_reset();
    dpre(5, 16'h0007);
    dpre(6, 16'hFFFF);
    emit(16'h4105);
    emit(enc_i(1, 0, 2, 6));
    emit(16'h0A60);
    emit(enc_i(2, 0, 3, 7));
    emit(enc_r(1, 2, 4, 1));
    emit(enc_r(1, 2, 5, 2));
    emit(enc_r(1, 2, 6, 3));
    emit(enc_r(2, 1, 7, 4));
    for (int i = 4; i < 8; i++) emit(enc_i(2, 0, i, i + 4));
    emit(enc_r(1, 2, 7, 4));
    emit(enc_i(2, 0, 7, 12));
    emit(enc_i(3, 1, 0, 5));
    emit(enc_i(3, 2, 2, 2));
    emit(enc_i(2, 0, 1, 13));
    run = 1'b1;
    drain("alu");

    // Backward branch from pc 4 to 3, with no data traffic.
    do_reset();
    for (int i = 0; i < 4; i++) emit(enc_r(0, 0, 0, 31));
    emit(16'hC0FE);
    dreq_cycles = 0;
    run = 1'b1;
    drain("br");
    check("br_no_dmem", dreq_cycles, 0);

    // Wait states on both memories.
    do_reset();
    iw = 3;
    dw = 2;
    dpre(5, 16'h0123);
    emit(16'h4105);
    emit(enc_i(2, 0, 1, 9));
    d_xfers = 0;
    run = 1'b1;
    drain("wait");
    check("wait_xfers", d_xfers, 2);

    // r0 write discarded, illegal funct retires as NOP.
    do_reset();
    dpre(5, 16'h0007);
    emit(16'h4105);
    emit(enc_r(1, 1, 0, 0));
    emit(enc_r(1, 1, 2, 31));
    emit(enc_i(2, 0, 0, 20));
    emit(enc_i(2, 0, 2, 21));
    emit(enc_i(2, 0, 1, 22));
    run = 1'b1;
    drain("r0nop");

    // Reset while a load is waiting on dmem_ack.
    do_reset();
    dw = 50;
    dpre(5, 16'h1234);
    emit(enc_i(1, 0, 3, 5));
    run = 1'b1;
    for (int i = 0; i < 100 && !dmem_req; i++) @(negedge clk);
    check("rst_lw_dreq_seen", {31'd0, dmem_req}, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_lw_dmem_req", {31'd0, dmem_req}, 0);
    check("rst_lw_imem_req", {31'd0, imem_req}, 0);
    check("rst_lw_pc", pc, 0);
    do_reset();
    emit(enc_i(2, 0, 3, 8));
    run = 1'b1;
    @(negedge clk);
    check("restart_req", {31'd0, imem_req}, 1);
    check("restart_addr", imem_addr, 0);
    drain("rstlw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mcycle_core.md
Name: mcycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle 16-bit datapath; keeps the same 16-bit instruction encoding.
- Internal FSM sequences FETCH/DECODE/EXEC/MEM/WB over shared resources. Instruction and data memories are external, on req/ack handshakes.
- Adds data width, address width, wait-state tolerant memories and a working branch.

Parameters:
- DATA_W, 16, register/ALU/data-memory width (>=16).
- ADDR_W, 16, PC and data address width (<=DATA_W).
- NREG, 8, register count; fixed by 3-bit fields; r0 reads 0.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  leave IDLE / continue at instruction boundary
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  word address (=pc)
- imem_ack  in  1  fetch complete, imem_rdata valid
- imem_rdata  in  16  instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  ADDR_W  data word address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete; load data valid
- dmem_rdata  in  DATA_W  load data
- instr_done  out  1  one-cycle pulse per retired instruction
- pc  out  ADDR_W  current program counter

Behaviour:
- Encoding: op=[15:14], rs=[13:11], rt=[10:8], rd=[7:5], funct=[4:0], imm=[7:0], sign-extended to needed width.
- op 00 R-type: rd=rs OP rt. funct 0 add, 1 sub, 2 and, 3 or, 4 slt (signed, result 1/0). Other funct = NOP, still retires.
- op 01 lw: rt=mem[rs+sext(imm)]. op 10 sw: mem[rs+sext(imm)]=rt. op 11 beq: if rs==rt, pc=pc+1+sext(imm), else pc+1.
- Arithmetic wraps mod 2^DATA_W. Address = low ADDR_W bits of sum. PC wraps mod 2^ADDR_W.
- Writes to r0 discarded. All registers 0 after reset.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE->FETCH when run=1.
- FETCH: imem_req=1. Advance on imem_ack; latch IR.
- DECODE: read rs/rt. EXEC: ALU / address / compare.
- MEM: lw, sw only. WB: R-type, lw only.
- Retire on final state; pc updated in the same cycle.
- After retire: FETCH if run=1, else IDLE.
- Latency with zero-wait ack: R 4 cycles, lw 5, sw 4, beq 3.
- Handshake:
  - req asserted on state entry and held until the cycle ack is sampled high at clk.
  - addr/we/wdata stable while req=1.
  - ack with req=0 ignored.
  - Ack may arrive in the first req cycle; unlimited wait states.
- run dropping mid-instruction has no effect until retire.
- Reset values: state IDLE, pc 0, imem_req 0, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, instr_done 0.
- Reset mid-access: req deasserts asynchronously; the outstanding transfer is abandoned and no register is written.

Optional Feature:
- MCYC_TRACE_EN defined: adds outputs trace_pc (ADDR_W), trace_wen (1), trace_waddr (3), trace_wdata (DATA_W). These are valid with instr_done and give the retiring instruction's PC and its register write (trace_wen=0 for sw/beq/NOP/r0). All reset to 0.
- MCYC_TRACE_EN undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Load/store: imem[0]=0x4105 (lw r1,5(r0)), imem[1]=0x8106 (sw r1,6(r0)), dmem[5]=0x0007, zero-wait -> one dmem write addr 6, data 0x0007, we=1; lw retires 5 cycles after FETCH entry.
- Wrap add: r1=0x0007, r2=0xFFFF preloaded via lw, 0x0A60 (add r3,r1,r2) -> r3=0x0006 (observed by sw); instr_done one cycle only.
- Branch: pc=4, imem[4]=0xC0FE (beq r0,r0,-2) -> next imem_addr=3; 3 cycles to retire; no dmem_req.
- Wait states: imem_ack delayed 3 cycles, dmem_ack 2 -> imem_req and dmem_req held high, addr stable, single transfer each; spurious ack while idle ignored.
- r0 and illegal funct: add r0,r1,r1 then funct=31 R-type -> r0 still reads 0; NOP retires, no state change.
- Reset mid-lw with dmem_req=1 -> dmem_req=0 immediately, pc=0, target register unchanged (still 0), restart fetch at 0 when run=1.
